// File: rtl/payload_seg_if.sv
// Request/segment stream bundle for payload_seg_engine.
// seg_pad exists only when PAYLOAD_SEG_PAD_EN is defined.
interface payload_seg_if #(
  parameter int LEN_W = 16,
  parameter int SEQ_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [LEN_W-1:0] req_bytes;
  logic             abort;
  logic             seg_valid;
  logic             seg_ready;
  logic [LEN_W-1:0] seg_len;
  logic             seg_first;
  logic             seg_last;
  logic [SEQ_W-1:0] seg_idx;
  logic             busy;
  logic             err_zero;
`ifdef PAYLOAD_SEG_PAD_EN
  logic [LEN_W-1:0] seg_pad;

  modport master (
    output req_valid, req_bytes, abort, seg_ready,
    input  req_ready, seg_valid, seg_len, seg_first, seg_last, seg_idx, busy, err_zero, seg_pad
  );
  modport slave (
    input  req_valid, req_bytes, abort, seg_ready,
    output req_ready, seg_valid, seg_len, seg_first, seg_last, seg_idx, busy, err_zero, seg_pad
  );
`else
  modport master (
    output req_valid, req_bytes, abort, seg_ready,
    input  req_ready, seg_valid, seg_len, seg_first, seg_last, seg_idx, busy, err_zero
  );
  modport slave (
    input  req_valid, req_bytes, abort, seg_ready,
    output req_ready, seg_valid, seg_len, seg_first, seg_last, seg_idx, busy, err_zero
  );
`endif
endinterface

// File: rtl/payload_seg_engine.sv
// Splits a transfer byte count into per-frame payload lengths with tail balancing.
// Optional macro PAYLOAD_SEG_PAD_EN adds seg_pad (bytes needed to reach MIN_PAYLOAD).
module payload_seg_engine #(
  parameter int LEN_W          = 16,
  parameter int MAX_PAYLOAD    = 1500,
  parameter int BALANCE_MARGIN = 100,
  parameter int MIN_PAYLOAD    = 46,
  parameter int SEQ_W          = 8
) (
  input logic          clk,
  input logic          rst_n,
  payload_seg_if.slave bus
);

  typedef enum logic {IDLE, SEG} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] BAL_TH  = LEN_W'(MAX_PAYLOAD + BALANCE_MARGIN);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PAYLOAD);

  // Remaining counts just above one frame are halved so the tail is never a runt.
  function automatic logic [LEN_W-1:0] seg_len_fn(input logic [LEN_W-1:0] rem);
    if (rem > BAL_TH)       return MAX_LEN;
    else if (rem > MAX_LEN) return rem >> 1;
    else                    return rem;
  endfunction

  function automatic logic [LEN_W-1:0] pad_len_fn(input logic [LEN_W-1:0] len);
    return (len < MIN_LEN) ? (MIN_LEN - len) : '0;
  endfunction

  state_t           state, state_nx;
  logic [LEN_W-1:0] remain;
  logic [SEQ_W-1:0] idx;
  logic             first;
  logic             err_zero_q;
  logic [LEN_W-1:0] len_cur;
  logic             last_cur;
  logic             req_go, req_zero, seg_hs;

  assign len_cur  = seg_len_fn(remain);
  assign last_cur = ((remain - len_cur) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req_go        = 1'b0;
    req_zero      = 1'b0;
    seg_hs        = 1'b0;
    bus.req_ready = 1'b0;
    bus.seg_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.seg_len   = '0;
    bus.seg_first = 1'b0;
    bus.seg_last  = 1'b0;
    bus.seg_idx   = '0;
    bus.err_zero  = err_zero_q;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        req_go        = bus.req_valid && (bus.req_bytes != '0);
        req_zero      = bus.req_valid && (bus.req_bytes == '0);
        if (req_go) state_nx = SEG;
      end
      SEG: begin
        bus.seg_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.seg_len   = len_cur;
        bus.seg_first = first;
        bus.seg_last  = last_cur;
        bus.seg_idx   = idx;
        seg_hs        = bus.seg_ready;
        if (seg_hs && last_cur) state_nx = IDLE;
      end
    endcase
    // Abort overrides everything except reset; a same-cycle handshake is still delivered.
    if (bus.abort) begin
      state_nx = IDLE;
      req_go   = 1'b0;
      req_zero = 1'b0;
    end
  end

`ifdef PAYLOAD_SEG_PAD_EN
  assign bus.seg_pad = (state == SEG) ? pad_len_fn(len_cur) : '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || bus.abort) begin
      remain     <= '0;
      idx        <= '0;
      first      <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      err_zero_q <= req_zero;
      if (req_go) begin
        remain <= bus.req_bytes;
        idx    <= '0;
        first  <= 1'b1;
      end else if (seg_hs) begin
        remain <= remain - len_cur;
        idx    <= idx + SEQ_W'(1);
        first  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_payload_seg_engine.sv
// Randomized and directed bench for payload_seg_engine against a list-based segmentation model.
// Define PAYLOAD_SEG_PAD_EN for both files to also exercise seg_pad.
module tb_payload_seg_engine;
  localparam int LEN_W  = 16;
  localparam int SEQ_W  = 8;
  localparam int MAXP   = 1500;
  localparam int MARGIN = 100;
  localparam int MINP   = 46;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             first;
    logic             last;
    logic [SEQ_W-1:0] idx;
  } seg_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  payload_seg_if #(.LEN_W(LEN_W), .SEQ_W(SEQ_W)) bus ();

  payload_seg_engine #(
    .LEN_W(LEN_W), .MAX_PAYLOAD(MAXP), .BALANCE_MARGIN(MARGIN),
    .MIN_PAYLOAD(MINP), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  seg_t exp_q[$];
  seg_t obs_q[$];
  int   bad_hold;
  bit   timed_out;

  // Reference: whole frames while more than a frame+margin remains, then one frame or two halves.
  task automatic build_expected(input int bytes);
    int lens[$];
    int rem;
    seg_t s;
    rem = bytes;
    exp_q.delete();
    while (rem > 0) begin
      if (rem > MAXP + MARGIN) begin
        lens.push_back(MAXP);
        rem -= MAXP;
      end else if (rem > MAXP) begin
        lens.push_back(rem / 2);
        lens.push_back(rem - rem / 2);
        rem = 0;
      end else begin
        lens.push_back(rem);
        rem = 0;
      end
    end
    foreach (lens[i]) begin
      s.len   = LEN_W'(lens[i]);
      s.first = (i == 0);
      s.last  = (i == lens.size() - 1);
      s.idx   = SEQ_W'(i % (1 << SEQ_W));
      exp_q.push_back(s);
    end
  endtask

  task automatic send_req(input int bytes);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_bytes = LEN_W'(bytes);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Records handshaken segments; counts any change of outputs while stalled.
  task automatic collect(input int ready_pct, input int stall_at, input int stall_len, input int max_hs);
    int   hs, stall, cyc;
    bit   done, rdy, prev_hold;
    seg_t cur, prev;
    obs_q.delete();
    bad_hold = 0; timed_out = 0; hs = 0; stall = 0; cyc = 0; done = 0; prev_hold = 0;
    prev = '0;
    while (!done) begin
      if (cyc >= 2000) begin
        timed_out = 1;
        break;
      end
      if (hs == stall_at && stall < stall_len && bus.seg_valid) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      bus.seg_ready = rdy;
      cur = '{bus.seg_len, bus.seg_first, bus.seg_last, bus.seg_idx};
      if (prev_hold && cur != prev) bad_hold++;
      prev_hold = bus.seg_valid && !rdy;
      prev = cur;
      if (bus.seg_valid && rdy) begin
        obs_q.push_back(cur);
        hs++;
        if (cur.last || hs == max_hs) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    bus.seg_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_bytes = '0; bus.abort = 0; bus.seg_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.seg_valid, bus.busy, bus.err_zero, bus.seg_first, bus.seg_last} !== 6'b100000
        || bus.seg_len !== '0 || bus.seg_idx !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%0b vld=%0b busy=%0b err=%0b first=%0b last=%0b len=%0d idx=%0d, want rdy=1 others 0",
               bus.req_ready, bus.seg_valid, bus.busy, bus.err_zero, bus.seg_first, bus.seg_last, bus.seg_len, bus.seg_idx);
    end
  endtask

  task automatic test_single();
    build_expected(1000);
    send_req(1000);
    checks++;
    if (bus.seg_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: vld=%0b busy=%0b rdy=%0b, want 1 1 0", bus.seg_valid, bus.busy, bus.req_ready);
    end
    collect(100, -1, 0, 0);
    checks++;
    if (timed_out || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL single_seg: n=%0d len=%0d f/l/idx=%0b/%0b/%0d timeout=%0b, want 1 seg len=1000 1/1/0",
               obs_q.size(), obs_q.size() ? obs_q[0].len : 0, obs_q.size() ? obs_q[0].first : 0,
               obs_q.size() ? obs_q[0].last : 0, obs_q.size() ? obs_q[0].idx : 0, timed_out);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: rdy=%0b busy=%0b vld=%0b, want 1 0 0", bus.req_ready, bus.busy, bus.seg_valid);
    end
  endtask

  task automatic test_boundaries();
    int sizes[9] = '{1550, 3100, 1601, 1600, 1500, 1501, 1602, 1, 3200};
    foreach (sizes[k]) begin
      build_expected(sizes[k]);
      send_req(sizes[k]);
      collect(100, -1, 0, 0);
      checks++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL bound_%0d_count: got %0d segs timeout=%0b, want %0d", sizes[k], obs_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bound_%0d_seg%0d: got len=%0d f=%0b l=%0b idx=%0d, want len=%0d f=%0b l=%0b idx=%0d",
                   sizes[k], i, obs_q[i].len, obs_q[i].first, obs_q[i].last, obs_q[i].idx,
                   exp_q[i].len, exp_q[i].first, exp_q[i].last, exp_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    build_expected(4000);
    send_req(4000);
    collect(100, 1, 5, 0);
    checks++;
    if (bad_hold != 0 || timed_out) begin
      errors++;
      $display("FAIL hold_stable: changes under stall=%0d timeout=%0b, want 0 0", bad_hold, timed_out);
    end
    checks++;
    if (obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1] || obs_q[2] !== exp_q[2]) begin
      errors++;
      $display("FAIL hold_seq: got n=%0d lens=%0d,%0d,%0d, want 1500,1500,1000 idx 0,1,2",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].len : 0,
               obs_q.size() > 1 ? obs_q[1].len : 0, obs_q.size() > 2 ? obs_q[2].len : 0);
    end
  endtask

  task automatic test_zero();
    int err_cycles = 0;
    int vld_cycles = 0;
    int rdy_low    = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_bytes = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) begin
      err_cycles += bus.err_zero;
      vld_cycles += bus.seg_valid;
      rdy_low    += !bus.req_ready;
      @(negedge clk);
    end
    checks++;
    if (err_cycles != 1 || vld_cycles != 0 || rdy_low != 0) begin
      errors++;
      $display("FAIL zero_req: err cycles=%0d vld cycles=%0d rdy-low cycles=%0d, want 1 0 0", err_cycles, vld_cycles, rdy_low);
    end
  endtask

  task automatic test_abort();
    build_expected(5000);
    send_req(5000);
    collect(100, -1, 0, 2);
    checks++;
    if (timed_out || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL abort_pre: n=%0d timeout=%0b, want 2 segs 1500/idx0 and 1500/idx1", obs_q.size(), timed_out);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.seg_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: vld=%0b busy=%0b rdy=%0b, want 0 0 1", bus.seg_valid, bus.busy, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_bytes = LEN_W'(300);
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    checks++;
    if (bus.seg_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: vld=%0b busy=%0b, want 0 0", bus.seg_valid, bus.busy);
    end
    send_req(200);
    checks++;
    if (bus.seg_valid !== 1'b1 || bus.seg_len !== LEN_W'(200) || bus.seg_first !== 1'b1
        || bus.seg_last !== 1'b1 || bus.seg_idx !== '0) begin
      errors++;
      $display("FAIL abort_next: vld=%0b len=%0d f=%0b l=%0b idx=%0d, want 1 200 1 1 0",
               bus.seg_valid, bus.seg_len, bus.seg_first, bus.seg_last, bus.seg_idx);
    end
    collect(100, -1, 0, 0);
  endtask

  task automatic test_random();
    int bytes;
    for (int t = 0; t < 25; t++) begin
      bytes = ($urandom_range(2) == 0) ? int'($urandom_range(MAXP + MARGIN + 8, 1))
                                       : int'($urandom_range(12000, 1));
      build_expected(bytes);
      send_req(bytes);
      collect(60, -1, 0, 0);
      checks++;
      if (timed_out || bad_hold != 0 || obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_%0d_bytes%0d: segs=%0d hold_changes=%0d timeout=%0b, want segs=%0d 0 0",
                 t, bytes, obs_q.size(), bad_hold, timed_out, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_%0d_seg%0d: got len=%0d f=%0b l=%0b idx=%0d, want len=%0d f=%0b l=%0b idx=%0d",
                   t, i, obs_q[i].len, obs_q[i].first, obs_q[i].last, obs_q[i].idx,
                   exp_q[i].len, exp_q[i].first, exp_q[i].last, exp_q[i].idx);
        end
      end
    end
  endtask

`ifdef PAYLOAD_SEG_PAD_EN
  task automatic test_pad();
    checks++;
    if (bus.seg_pad !== '0) begin
      errors++;
      $display("FAIL pad_idle: got %0d, want 0", bus.seg_pad);
    end
    send_req(20);
    checks++;
    if (bus.seg_pad !== LEN_W'(MINP - 20)) begin
      errors++;
      $display("FAIL pad_short: got %0d, want %0d", bus.seg_pad, MINP - 20);
    end
    collect(100, -1, 0, 0);
    send_req(1550);
    checks++;
    if (bus.seg_pad !== '0) begin
      errors++;
      $display("FAIL pad_long: got %0d, want 0", bus.seg_pad);
    end
    collect(100, -1, 0, 0);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_backpressure();
    test_zero();
    test_abort();
    test_random();
`ifdef PAYLOAD_SEG_PAD_EN
    test_pad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/payload_seg_engine.md
Name: payload_seg_engine

Overview:
- Parametrised successor to the transmitter's payload length calculator.
- Accepts a total byte count per transfer request and emits a sequence of per-frame payload lengths over a valid/ready stream.
- Each emitted length carries first/last/index tags.
- Tail balancing avoids a runt final frame.
- Sits between the pattern-generator control FSM and the frame builder.

Parameters:
- LEN_W, 16: width of byte counts and lengths.
- MAX_PAYLOAD, 1500: largest payload per frame.
- BALANCE_MARGIN, 100: remaining counts in (MAX_PAYLOAD, MAX_PAYLOAD+BALANCE_MARGIN] are split into two halves.
- MIN_PAYLOAD, 46: minimum frame payload; used only with the optional feature.
- SEQ_W, 8: width of segment index.
- Legal configurations: MAX_PAYLOAD+BALANCE_MARGIN < 2**LEN_W; BALANCE_MARGIN < MAX_PAYLOAD.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  transfer request valid
- req_ready  out  1  engine idle, can accept request
- req_bytes  in  LEN_W  total bytes for the transfer
- abort  in  1  synchronous cancel of the current transfer
- seg_valid  out  1  segment length valid
- seg_ready  in  1  frame builder accepts segment
- seg_len  out  LEN_W  payload length of the current segment
- seg_first  out  1  first segment of the transfer
- seg_last  out  1  final segment of the transfer
- seg_idx  out  SEQ_W  segment index within the transfer
- busy  out  1  transfer in progress
- err_zero  out  1  one-cycle pulse: zero-length request rejected

Behaviour:
- Reset: state IDLE, remain=0, idx=0, first flag=0.
  - Outputs: seg_valid=0, seg_len=0, seg_first=0, seg_last=0, seg_idx=0, busy=0, err_zero=0.
  - req_ready=1 in the first cycle after reset release.
- FSM states: IDLE, SEG.
- IDLE:
  - req_ready=1, seg_valid=0, busy=0.
  - On req_valid with req_bytes==0: err_zero=1 next cycle for one cycle; stay IDLE; no segments emitted.
  - On req_valid with req_bytes!=0: remain<=req_bytes, idx<=0, first<=1, go to SEG.
  - seg_valid rises the cycle after request acceptance (1-cycle latency).
- SEG:
  - req_ready=0, busy=1, seg_valid=1.
  - seg_len is combinational from registered remain:
    - remain > MAX_PAYLOAD+BALANCE_MARGIN: MAX_PAYLOAD;
    - else remain > MAX_PAYLOAD: remain>>1 (floor);
    - else: remain.
  - seg_last = ((remain - seg_len) == 0); seg_first = first flag; seg_idx = idx.
  - On seg_valid && seg_ready: remain <= remain - seg_len; idx <= idx+1 (wraps modulo 2**SEQ_W); first <= 0. If seg_last, go to IDLE.
  - Without a handshake, seg_len/seg_first/seg_last/seg_idx hold stable (no change under backpressure).
- A balanced split yields floor then ceil halves; both are <= (MAX_PAYLOAD+BALANCE_MARGIN+1)/2.
- After the last segment handshake, req_ready asserts in the next cycle. There is a one-cycle bubble between transfers; requests are never accepted in SEG.
- abort:
  - Any state; priority below reset, above everything else.
  - Next cycle: IDLE, remain=0, idx=0, seg_valid=0.
  - A segment handshaking in the same cycle as abort counts as delivered, but no further segments follow.
  - abort together with req_valid in IDLE: the request is dropped.
- Arithmetic is unsigned LEN_W. Subtraction never underflows by construction.
- Sum of seg_len over a transfer equals req_bytes exactly.

Optional Feature:
- Macro: PAYLOAD_SEG_PAD_EN.
- Defined:
  - Adds output seg_pad (LEN_W).
  - seg_pad = MIN_PAYLOAD - seg_len when seg_len < MIN_PAYLOAD, else 0.
  - seg_pad is valid with seg_valid, stable under backpressure, 0 at reset and in IDLE.
  - Segmentation is unchanged.
- Undefined: no seg_pad port and no padding logic. All other behaviour is identical.

Test Plan:
- req_bytes=1000, seg_ready=1 -> one segment: len=1000, first=1, last=1, idx=0; req_ready=1 two cycles after acceptance.
- req_bytes=1550 -> segments 775 (first, idx0), 775 (last, idx1).
- req_bytes=3100 -> 1500, 800, 800; idx 0,1,2; only the third has last=1; req_bytes=1601 -> 1500, 101.
- req_bytes=4000 with seg_ready low 5 cycles on segment 2 -> seg_len=1500 and idx=1 held stable throughout; sequence 1500, 1500, 1000 completes.
- req_bytes=0 -> err_zero high exactly one cycle, seg_valid never asserts, req_ready stays 1.
- req_bytes=5000, abort after 2 handshakes -> seg_valid=0 next cycle, busy=0, req_ready=1; a new request of 200 yields len=200, first=1, idx=0. With PAYLOAD_SEG_PAD_EN: req 20 -> seg_pad=26; req 1550 -> seg_pad=0.
